// File: rtl/shared_adder_arbiter.sv
// -----------------------------------------------------------------------------
// shared_adder_arbiter
//
// One DW-bit adder shared by N_REQ requesters under round-robin arbitration.
// A granted request is added in the grant cycle and its result is registered,
// tagged with the requester ID, the arithmetic mode and an overflow flag.
// The result register is a one-entry output stage with valid/ready handshake;
// a retiring result and a new grant may share an edge, so throughput is one
// result per cycle while out_ready stays high.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   req_valid   per-requester operation pending
//   req_signed  per-requester two's-complement mode
//   req_d1      packed addend 1, requester i at [i*DW +: DW]
//   req_d2      packed addend 2, same packing
//   req_ready   one-hot grant (combinational)
//   out_valid   result register holds a valid result
//   out_ready   downstream accepts the result this cycle
//   out_sum     (d1 + d2) mod 2^DW
//   out_ovf     unsigned carry-out or signed overflow, depending on mode
//   out_id      index of the requester that produced the result
//   out_signed  mode used for this result
// -----------------------------------------------------------------------------
module shared_adder_arbiter #(
    parameter int DW    = 4,
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_signed,
    input  logic [N_REQ*DW-1:0] req_d1,
    input  logic [N_REQ*DW-1:0] req_d2,
    output logic [N_REQ-1:0]    req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_sum,
    output logic                out_ovf,
    output logic [IDW-1:0]      out_id,
    output logic                out_signed
);

    logic [IDW-1:0] last_q, last_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_sum_q, out_sum_d;
    logic           out_ovf_q, out_ovf_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic           out_signed_q, out_signed_d;

    logic           accept;
    logic           found;
    logic           transfer;
    logic [IDW-1:0] grant_idx;
    logic [DW-1:0]  sel_d1, sel_d2;
    logic           sel_signed;
    logic [DW:0]    sum_ext;
    logic           ovf;

    // The output stage can take a new result when it is empty or draining.
    assign accept = !out_valid_q || out_ready;

    // Round-robin search: probe (last+1), (last+2), ... modulo N_REQ and take
    // the first requester with valid set. The modulo keeps IDs below N_REQ
    // even when N_REQ is not a power of two.
    always_comb begin : arbitrate
        // NOTE: every variable gets a default before any conditional write so
        // that no path leaves it unassigned, which would infer a latch.
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(last_q) + k) % N_REQ)) begin
                    found     = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

    // No grant while reset is asserted, even though the empty output stage
    // would otherwise accept.
    assign transfer = rst && accept && found;

    always_comb begin : grant_decode
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = transfer && (grant_idx == IDW'(i));
        end
    end

    // Operand mux feeding the single shared adder.
    always_comb begin : operand_mux
        sel_d1     = '0;
        sel_d2     = '0;
        sel_signed = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_d1     = req_d1[i*DW +: DW];
                sel_d2     = req_d2[i*DW +: DW];
                sel_signed = req_signed[i];
            end
        end
    end

    // One extra bit captures the unsigned carry; signed overflow is the
    // classic "same-sign operands, different-sign result" test.
    assign sum_ext = {1'b0, sel_d1} + {1'b0, sel_d2};
    assign ovf     = sel_signed
                   ? ((sel_d1[DW-1] == sel_d2[DW-1]) && (sum_ext[DW-1] != sel_d1[DW-1]))
                   : sum_ext[DW];

    // Result fields load only on a transfer; otherwise they hold, so a
    // retired result stays visible (with out_valid low) until replaced.
    always_comb begin : next_state
        out_valid_d  = transfer || (out_valid_q && !out_ready);
        out_sum_d    = out_sum_q;
        out_ovf_d    = out_ovf_q;
        out_id_d     = out_id_q;
        out_signed_d = out_signed_q;
        last_d       = last_q;
        if (transfer) begin
            out_sum_d    = sum_ext[DW-1:0];
            out_ovf_d    = ovf;
            out_id_d     = grant_idx;
            out_signed_d = sel_signed;
            last_d       = grant_idx;
        end
    end

    // Pointer resets to N_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the result fields are reset too, not just out_valid, so the
            // outputs are defined from the first cycle after reset.
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_ovf_q    <= 1'b0;
            out_id_q     <= '0;
            out_signed_q <= 1'b0;
            last_q       <= IDW'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others.
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_ovf_q    <= out_ovf_d;
            out_id_q     <= out_id_d;
            out_signed_q <= out_signed_d;
            last_q       <= last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_ovf    = out_ovf_q;
    assign out_id     = out_id_q;
    assign out_signed = out_signed_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_adder_arbiter
//
// Directed sequence followed by randomized traffic. A behavioural model keeps
// the round-robin pointer as an integer and computes sums and overflow with
// plain integer arithmetic; every cycle the grant vector and all outputs are
// compared against it.
// -----------------------------------------------------------------------------
module tb_shared_adder_arbiter;

    localparam int DW    = 4;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int MOD   = 1 << DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_signed;
    logic [N*DW-1:0]   req_d1;
    logic [N*DW-1:0]   req_d2;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_sum;
    logic              out_ovf;
    logic [IDW-1:0]    out_id;
    logic              out_signed;

    shared_adder_arbiter #(.DW(DW), .N_REQ(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_signed (req_signed),
        .req_d1     (req_d1),
        .req_d2     (req_d2),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf),
        .out_id     (out_id),
        .out_signed (out_signed)
    );

    always #5 clk = ~clk;

    // Stimulus state per requester.
    bit vld[N];
    bit sg[N];
    int d1[N];
    int d2[N];

    // Behavioural model state.
    int m_last;
    bit m_valid;
    int m_sum;
    bit m_ovf;
    int m_id;
    bit m_sgn;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = vld[i];
            req_signed[i]         = sg[i];
            req_d1[i*DW +: DW]    = DW'(d1[i]);
            req_d2[i*DW +: DW]    = DW'(d2[i]);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            sg[i]  = 1'b0;
            d1[i]  = 0;
            d2[i]  = 0;
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 1'b0;
        m_sum   = 0;
        m_ovf   = 1'b0;
        m_id    = 0;
        m_sgn   = 1'b0;
    endtask

    // Granted requester index, or -1 when nothing is granted.
    function automatic int exp_grant();
        int p;
        if (!rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            p = (m_last + k) % N;
            if (vld[p]) return p;
        end
        return -1;
    endfunction

    // Arithmetic reference: operands interpreted as integers in the chosen mode.
    task automatic ref_add(input int a, input int b, input bit signed_mode,
                           output int sum, output bit ovf);
        int sa, sb, s;
        if (signed_mode) begin
            sa  = (a >= MOD / 2) ? a - MOD : a;
            sb  = (b >= MOD / 2) ? b - MOD : b;
            s   = sa + sb;
            ovf = (s > MOD / 2 - 1) || (s < -(MOD / 2));
            sum = (s + 2 * MOD) % MOD;
        end else begin
            s   = a + b;
            ovf = (s >= MOD);
            sum = s % MOD;
        end
    endtask

    // One clock: drive, check at the falling edge, advance model at the rising
    // edge, return 1 time unit after it.
    task automatic cycle();
        int g;
        int s;
        bit o;
        apply();
        @(negedge clk);
        g = exp_grant();
        check("req_ready",  req_ready,  (g >= 0) ? (32'd1 << g) : 32'd0);
        check("out_valid",  out_valid,  m_valid);
        check("out_sum",    out_sum,    m_sum);
        check("out_ovf",    out_ovf,    m_ovf);
        check("out_id",     out_id,     m_id);
        check("out_signed", out_signed, m_sgn);
        @(posedge clk);
        if (g >= 0) begin
            ref_add(d1[g], d2[g], sg[g], s, o);
            m_sum   = s;
            m_ovf   = o;
            m_id    = g;
            m_sgn   = sg[g];
            m_valid = 1'b1;
            m_last  = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Asynchronous reset pulse applied between edges; outputs must clear at
    // once and no grant may appear while reset is low.
    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_req_ready", req_ready, '0);
        check("rst_out_sum",   out_sum,   '0);
        @(posedge clk);
        #1;
        check("rst_hold_ready", req_ready, '0);
        check("rst_hold_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input bit s);
        vld[i] = 1'b1;
        d1[i]  = a;
        d2[i]  = b;
        sg[i]  = s;
    endtask

    int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
    int frozen_sum;
    int frozen_id;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        out_ready = 1'b1;
        clear_reqs();
        model_reset();

        // Reset with traffic active.
        for (int i = 0; i < N; i++) set_req(i, i, i + 1, 1'b0);
        apply();
        #3;
        check("init_out_valid", out_valid, 1'b0);
        check("init_req_ready", req_ready, '0);
        @(posedge clk);
        #1;
        check("init_req_ready2", req_ready, '0);
        rst = 1'b1;

        // Only requester 2 active after reset.
        clear_reqs();
        set_req(2, 5, 6, 1'b0);
        apply();
        #1;
        check("first_grant", req_ready, 4'b0100);
        cycle();
        check("first_id", out_id, 2);
        check("first_valid", out_valid, 1'b1);

        // Unsigned.
        clear_reqs();
        set_req(0, 9, 9, 1'b0);
        cycle();
        check("u_9p9_sum", out_sum, 2);
        check("u_9p9_ovf", out_ovf, 1'b1);
        set_req(0, 3, 4, 1'b0);
        cycle();
        check("u_3p4_sum", out_sum, 7);
        check("u_3p4_ovf", out_ovf, 1'b0);

        // Signed on requester 1.
        clear_reqs();
        set_req(1, 7, 1, 1'b1);
        cycle();
        check("s_7p1_sum", out_sum, 4'b1000);
        check("s_7p1_ovf", out_ovf, 1'b1);
        set_req(1, 8, 15, 1'b1);
        cycle();
        check("s_m8m1_sum", out_sum, 7);
        check("s_m8m1_ovf", out_ovf, 1'b1);
        set_req(1, 13, 2, 1'b1);
        cycle();
        check("s_m3p2_sum", out_sum, 15);
        check("s_m3p2_ovf", out_ovf, 1'b0);
        check("s_mode", out_signed, 1'b1);
        clear_reqs();
        cycle();
        check("retire_valid", out_valid, 1'b0);

        // Round-robin from a fresh pointer.
        reset_pulse();
        for (int i = 0; i < N; i++) set_req(i, i + 2, 3 * i, i[0]);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_id", out_id, rr_seq[k]);
        end

        // Backpressure: three stalled cycles, then release.
        out_ready  = 1'b0;
        frozen_sum = m_sum;
        frozen_id  = m_id;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_sum_frozen", out_sum, frozen_sum);
            check("bp_id_frozen",  out_id,  frozen_id);
            check("bp_valid",      out_valid, 1'b1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_id", out_id, (frozen_id + 1) % N);
        check("bp_release_valid", out_valid, 1'b1);

        // Reset during a stall.
        out_ready = 1'b0;
        cycle();
        reset_pulse();
        out_ready = 1'b1;
        clear_reqs();
        set_req(1, 4, 4, 1'b0);
        set_req(3, 1, 1, 1'b0);
        cycle();
        check("post_rst_id", out_id, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 99) < 60);
                sg[i]  = $urandom_range(0, 1);
                d1[i]  = $urandom_range(0, MOD - 1);
                d2[i]  = $urandom_range(0, MOD - 1);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
